bp_fe_cache_req_arbiter: RTL and testbench
==========================================

// Module: bp_fe_cache_req_arbiter
// PURPOSE
//   Shares one I$ cache-engine request port between num_req_p front-end requesters
//   (slot 0: icache miss engine, slot 1: instruction prefetcher).
//   Round-robin grant; the grant is locked from request issue through metadata
//   until cache_req_complete_i. complete/critical are routed back to the owner only.
//   Sits between the FE requesters and the cache engine (LCE) interface.
// PARAMETERS
//   num_req_p       2   number of requesters (>=2)
//   req_width_p     64  width of one cache_req packet
//   md_width_p      8   width of one cache_req_metadata packet
// PORTS
//   clk_i            in   1                    clock
//   reset_i          in   1                    async active-high reset
//   block_i          in   1                    FE redirect/flush in progress: no new grants
//   req_i            in   num_req_p*req_width_p  packed requests, slot k at [k*req_width_p+:req_width_p]
//   req_v_i          in   num_req_p            request valid per slot
//   req_yumi_o       out  num_req_p            request accepted (onehot or 0)
//   req_metadata_i   in   num_req_p*md_width_p packed metadata per slot
//   req_metadata_v_i in   num_req_p            metadata valid per slot
//   req_complete_o   out  num_req_p            completion pulse to owner
//   req_critical_o   out  num_req_p            critical-word pulse to owner
//   busy_o           out  1                    transaction outstanding (state != IDLE)
//   cache_req_o      out  req_width_p          granted request
//   cache_req_v_o    out  1                    request valid to engine
//   cache_req_ready_i in  1                    engine ready
//   cache_req_metadata_o   out md_width_p      owner's metadata
//   cache_req_metadata_v_o out 1               metadata valid to engine
//   cache_req_complete_i   in  1               engine: transaction done
//   cache_req_critical_i   in  1               engine: critical data returned
// BEHAVIOUR
//   - FSM: IDLE -> META -> WAIT -> IDLE. Regs: state, owner (log2 num_req_p), rr_ptr.
//   - Reset (async): state=IDLE, owner=0, rr_ptr=0; all outputs 0 while reset_i high.
//   - IDLE: if ~block_i & |req_v_i, grant = first valid slot searching from rr_ptr
//     upward with wrap; cache_req_v_o=1, cache_req_o=req_i[grant] (combinational, 0-cycle).
//     On cache_req_ready_i: req_yumi_o[grant]=1, owner<=grant, rr_ptr<=grant+1 (wrap
//     to 0 at num_req_p), state<=META. No ready: stay IDLE, re-arbitrate next cycle.
//   - block_i=1 in IDLE: cache_req_v_o=0, no yumi; has no effect in META/WAIT.
//   - META: cache_req_metadata_o=req_metadata_i[owner], metadata_v_o=req_metadata_v_i[owner];
//     on that valid -> WAIT. Other slots' metadata ignored.
//   - WAIT: idle until cache_req_complete_i.
//   - complete_i in META or WAIT: req_complete_o[owner]=1 same cycle, state<=IDLE;
//     new grant possible the following cycle (1 idle bubble min). If metadata_v and
//     complete_i coincide in META, both forwarded, state<=IDLE.
//   - critical_i in META/WAIT: req_critical_o[owner]=1 same cycle; in IDLE ignored.
//   - complete_i in IDLE: ignored, no output pulse (assertion flags it).
//   - Exactly one transaction outstanding; req_yumi_o, complete_o, critical_o onehot0.
//   - Reset mid-transaction: FSM aborts to IDLE; no complete pulse issued.
// TESTING
//   1 Single: req_v_i=01, ready=1 -> yumi=01 cycle 0; md_v[0] cycle 1 -> md_v_o=1;
//     complete cycle 5 -> complete_o=01, busy_o falls cycle 6.
//   2 Fairness: req_v_i=11 held, ready=1, complete 3 cyc after md -> grants 0,1,0,1.
//   3 Backpressure: req_v_i=10, ready=0 for 4 cyc -> cache_req_v_o=1, yumi=00 each
//     cycle, cache_req_o stable; ready=1 cycle 4 -> yumi=10.
//   4 Block: block_i=1, req_v_i=11 -> cache_req_v_o=0 for all cycles; drop -> grant rr_ptr slot.
//   5 Corner: md_v and complete same cycle -> both forwarded, IDLE next; critical_i in
//     WAIT owner=1 -> critical_o=10.
//   6 Reset asserted in WAIT -> outputs 0 immediately, state=IDLE, rr_ptr=0.

Source files
------------

// File: rtl/bp_fe_cache_req_arbiter.sv
// Round-robin arbiter sharing one I$ cache-engine request port among FE requesters.
// The grant stays locked to its owner from request issue until the engine signals completion.
module bp_fe_cache_req_arbiter #(
    parameter int num_req_p   = 2,
    parameter int req_width_p = 64,
    parameter int md_width_p  = 8
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              block_i,
    input  logic [num_req_p*req_width_p-1:0]  req_i,
    input  logic [num_req_p-1:0]              req_v_i,
    output logic [num_req_p-1:0]              req_yumi_o,
    input  logic [num_req_p*md_width_p-1:0]   req_metadata_i,
    input  logic [num_req_p-1:0]              req_metadata_v_i,
    output logic [num_req_p-1:0]              req_complete_o,
    output logic [num_req_p-1:0]              req_critical_o,
    output logic                              busy_o,
    output logic [req_width_p-1:0]            cache_req_o,
    output logic                              cache_req_v_o,
    input  logic                              cache_req_ready_i,
    output logic [md_width_p-1:0]             cache_req_metadata_o,
    output logic                              cache_req_metadata_v_o,
    input  logic                              cache_req_complete_i,
    input  logic                              cache_req_critical_i
);

    localparam int lg_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        META = 2'd1,
        WAIT = 2'd2
    } state_e;

    state_e            state_r, state_n;
    logic [lg_w-1:0]   owner_r, owner_n;
    logic [lg_w-1:0]   rr_r, rr_n;
    logic [lg_w-1:0]   grant;
    logic              grant_v;

    // Walk downward so the slot closest to rr_r (searching upward with wrap) wins.
    always_comb begin : arb
        int idx;
        grant   = '0;
        grant_v = 1'b0;
        idx     = 0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            idx = (int'(rr_r) + i) % num_req_p;
            if (req_v_i[idx]) begin
                grant   = lg_w'(idx);
                grant_v = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            owner_r <= '0;
            rr_r    <= '0;
        end else begin
            state_r <= state_n;
            owner_r <= owner_n;
            rr_r    <= rr_n;
        end
    end

    always_comb begin
        state_n                = state_r;
        owner_n                = owner_r;
        rr_n                   = rr_r;
        req_yumi_o             = '0;
        req_complete_o         = '0;
        req_critical_o         = '0;
        cache_req_o            = '0;
        cache_req_v_o          = 1'b0;
        cache_req_metadata_o   = '0;
        cache_req_metadata_v_o = 1'b0;
        busy_o                 = (state_r != IDLE);
        if (!reset_i) begin
            unique case (state_r)
                IDLE: begin
                    if (!block_i && grant_v) begin
                        cache_req_v_o = 1'b1;
                        cache_req_o   = req_i[int'(grant)*req_width_p +: req_width_p];
                        if (cache_req_ready_i) begin
                            req_yumi_o[grant] = 1'b1;
                            owner_n           = grant;
                            rr_n              = (int'(grant) == num_req_p - 1)
                                              ? '0 : grant + 1'b1;
                            state_n           = META;
                        end
                    end
                end
                META, WAIT: begin
                    if (state_r == META) begin
                        cache_req_metadata_o   =
                            req_metadata_i[int'(owner_r)*md_width_p +: md_width_p];
                        cache_req_metadata_v_o = req_metadata_v_i[owner_r];
                        if (req_metadata_v_i[owner_r]) state_n = WAIT;
                    end
                    if (cache_req_critical_i) req_critical_o[owner_r] = 1'b1;
                    // Completion overrides a same-cycle metadata handoff.
                    if (cache_req_complete_i) begin
                        req_complete_o[owner_r] = 1'b1;
                        state_n                 = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // An engine completion with nothing outstanding indicates a protocol bug upstream.
    a_no_idle_complete: assert property (@(posedge clk_i) disable iff (reset_i)
        !(state_r == IDLE && cache_req_complete_i));

    a_yumi_onehot0: assert property (@(posedge clk_i) disable iff (reset_i)
        $onehot0(req_yumi_o));

endmodule

// File: tb/tb_bp_fe_cache_req_arbiter.sv
// Randomized scoreboard bench for bp_fe_cache_req_arbiter.
// A transaction-level model predicts each cycle's outputs; a monitor compares them.
module tb_bp_fe_cache_req_arbiter;

    localparam int N  = 2;
    localparam int RW = 64;
    localparam int MW = 8;

    logic            clk;
    logic            reset_i;
    logic            block_i;
    logic [N*RW-1:0] req_i;
    logic [N-1:0]    req_v_i;
    logic [N-1:0]    req_yumi_o;
    logic [N*MW-1:0] req_metadata_i;
    logic [N-1:0]    req_metadata_v_i;
    logic [N-1:0]    req_complete_o;
    logic [N-1:0]    req_critical_o;
    logic            busy_o;
    logic [RW-1:0]   cache_req_o;
    logic            cache_req_v_o;
    logic            cache_req_ready_i;
    logic [MW-1:0]   cache_req_metadata_o;
    logic            cache_req_metadata_v_o;
    logic            cache_req_complete_i;
    logic            cache_req_critical_i;

    bp_fe_cache_req_arbiter #(
        .num_req_p   (N),
        .req_width_p (RW),
        .md_width_p  (MW)
    ) dut (
        .clk_i                  (clk),
        .reset_i                (reset_i),
        .block_i                (block_i),
        .req_i                  (req_i),
        .req_v_i                (req_v_i),
        .req_yumi_o             (req_yumi_o),
        .req_metadata_i         (req_metadata_i),
        .req_metadata_v_i       (req_metadata_v_i),
        .req_complete_o         (req_complete_o),
        .req_critical_o         (req_critical_o),
        .busy_o                 (busy_o),
        .cache_req_o            (cache_req_o),
        .cache_req_v_o          (cache_req_v_o),
        .cache_req_ready_i      (cache_req_ready_i),
        .cache_req_metadata_o   (cache_req_metadata_o),
        .cache_req_metadata_v_o (cache_req_metadata_v_o),
        .cache_req_complete_i   (cache_req_complete_i),
        .cache_req_critical_i   (cache_req_critical_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  yumi;
        logic [N-1:0]  cmp;
        logic [N-1:0]  crit;
        logic          busy;
        logic          v;
        logic [RW-1:0] req;
        logic          chk_md;
        logic          md_v;
        logic [MW-1:0] md;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_grants = 0;

    // Reference model: one outstanding transaction, owner, metadata pending, rr pointer
    bit   m_busy;
    bit   m_meta;
    int   m_owner;
    int   m_rr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("yumi",     64'(req_yumi_o),             64'(e.yumi));
            chk("complete", 64'(req_complete_o),         64'(e.cmp));
            chk("critical", 64'(req_critical_o),         64'(e.crit));
            chk("busy",     64'(busy_o),                 64'(e.busy));
            chk("req_v",    64'(cache_req_v_o),          64'(e.v));
            chk("md_v",     64'(cache_req_metadata_v_o), 64'(e.md_v));
            if (e.v)      chk("req_data", cache_req_o, e.req);
            if (e.chk_md) chk("md_data", 64'(cache_req_metadata_o), 64'(e.md));
        end
    end

    task automatic model_step(input bit rst, output exp_t x);
        int g;
        x = '0;
        if (rst) begin
            m_busy  = 0;
            m_meta  = 0;
            m_owner = 0;
            m_rr    = 0;
            return;
        end
        x.busy = m_busy;
        if (!m_busy) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                int s;
                s = (m_rr + k) % N;
                if (req_v_i[s] && g < 0) g = s;
            end
            if (!block_i && g >= 0) begin
                x.v   = 1'b1;
                x.req = req_i[g*RW +: RW];
                if (cache_req_ready_i) begin
                    x.yumi[g] = 1'b1;
                    m_busy    = 1;
                    m_meta    = 1;
                    m_owner   = g;
                    m_rr      = (g + 1) % N;
                    n_grants++;
                end
            end
        end else begin
            if (m_meta) begin
                x.chk_md = 1'b1;
                x.md     = req_metadata_i[m_owner*MW +: MW];
                x.md_v   = req_metadata_v_i[m_owner];
                if (x.md_v) m_meta = 0;
            end
            if (cache_req_critical_i) x.crit[m_owner] = 1'b1;
            if (cache_req_complete_i) begin
                x.cmp[m_owner] = 1'b1;
                m_busy         = 0;
                m_meta         = 0;
            end
        end
    endtask

    initial begin
        exp_t x;
        bit   rst;
        reset_i              = 1'b1;
        block_i              = 1'b0;
        req_i                = '0;
        req_v_i              = '0;
        req_metadata_i       = '0;
        req_metadata_v_i     = '0;
        cache_req_ready_i    = 1'b0;
        cache_req_complete_i = 1'b0;
        cache_req_critical_i = 1'b0;
        m_busy = 0; m_meta = 0; m_owner = 0; m_rr = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            rst = (cyc < 2) || ($urandom_range(0, 249) == 0);
            reset_i  = rst;
            // Long block window plus random short blocks
            block_i  = (cyc >= 1500 && cyc < 1540) || ($urandom_range(0, 4) == 0);
            req_v_i  = N'($urandom);
            req_i    = {$urandom(), $urandom(), $urandom(), $urandom()};
            req_metadata_i    = (N*MW)'($urandom);
            req_metadata_v_i  = N'($urandom);
            cache_req_ready_i = ($urandom_range(0, 2) == 0);
            cache_req_critical_i = ($urandom_range(0, 3) == 0);
            cache_req_complete_i = !rst && m_busy && ($urandom_range(0, 3) == 0);
            model_step(rst, x);
            if (rst) x = '0;
            q.push_back(x);
        end
        @(posedge clk);
        #1;
        reset_i              = 1'b0;
        req_v_i              = '0;
        cache_req_complete_i = 1'b0;
        cache_req_critical_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        n_checks++;
        if (n_grants < 50) begin
            n_fail++;
            $display("FAIL progress: got %0d grants expected at least 50", n_grants);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
